// File: rtl/math_pkg.sv
// Shared definitions for the sequential tiled multiplier: FSM encoding,
// default tile width and the ceil-div helper used to size the tile grid.
package math_pkg;

  localparam int TILE_DEFAULT = 17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/math_mult_tile.sv
// Unsigned TILE x TILE multiply, purely combinational; sized so that one
// instance maps onto a single DSP multiplier.
module math_mult_tile #(
  parameter int TILE = 17
) (
  input  logic [TILE-1:0]   a_i,
  input  logic [TILE-1:0]   b_i,
  output logic [2*TILE-1:0] p_o
);

  assign p_o = {{TILE{1'b0}}, a_i} * {{TILE{1'b0}}, b_i};

endmodule

// File: rtl/math_mult_seq.sv
// Sequential full-precision multiplier: operand magnitudes are cut into
// TILE-bit tiles and one tile pair is multiplied and accumulated per cycle.
module math_mult_seq
  import math_pkg::*;
#(
  parameter int WIDTH_A = 43,
  parameter int WIDTH_B = 35,
  parameter int TILE    = TILE_DEFAULT,
  parameter int SIGNED  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enb,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH_A-1:0]         a,
  input  logic [WIDTH_B-1:0]         b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH_A+WIDTH_B-1:0] p
);

  localparam int NA   = ceil_div(WIDTH_A, TILE);
  localparam int NB   = ceil_div(WIDTH_B, TILE);
  localparam int WP   = WIDTH_A + WIDTH_B;
  localparam int AEXT = NA * TILE;
  localparam int BEXT = NB * TILE;
  localparam int IW_A = (NA > 1) ? $clog2(NA) : 1;
  localparam int IW_B = (NB > 1) ? $clog2(NB) : 1;

  state_e            st_q;
  logic [AEXT-1:0]   am_q;
  logic [BEXT-1:0]   bm_q;
  logic              neg_q;
  logic [IW_A-1:0]   i_q;
  logic [IW_B-1:0]   j_q;
  logic [WP-1:0]     acc_q;
  logic [WP-1:0]     p_q;
  logic              ov_q;

  logic              a_neg, b_neg;
  logic [WIDTH_A-1:0] a_abs;
  logic [WIDTH_B-1:0] b_abs;
  logic [TILE-1:0]   ta, tb;
  logic [2*TILE-1:0] pp;
  logic [WP-1:0]     pp_ext;
  logic [31:0]       shamt;
  logic [WP-1:0]     acc_d;
  logic [WP-1:0]     p_d;
  logic              i_last, j_last;

  // Magnitude of the most negative value still fits in WIDTH bits unsigned.
  always_comb begin
    a_neg = (SIGNED != 0) && a[WIDTH_A-1];
    b_neg = (SIGNED != 0) && b[WIDTH_B-1];
    a_abs = a_neg ? (~a + WIDTH_A'(1)) : a;
    b_abs = b_neg ? (~b + WIDTH_B'(1)) : b;
  end

  assign ta = am_q[TILE*int'(i_q) +: TILE];
  assign tb = bm_q[TILE*int'(j_q) +: TILE];

  math_mult_tile #(.TILE(TILE)) u_tile (
    .a_i (ta),
    .b_i (tb),
    .p_o (pp)
  );

  // Each shifted partial product is bounded by the full product, so the
  // cast to WP bits never drops a set bit.
  always_comb begin
    pp_ext = WP'(pp);
    shamt  = 32'((int'(i_q) + int'(j_q)) * TILE);
    acc_d  = acc_q + (pp_ext << shamt);
    p_d    = neg_q ? (~acc_d + WP'(1)) : acc_d;
    i_last = (i_q == IW_A'(NA - 1));
    j_last = (j_q == IW_B'(NB - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= ST_IDLE;
      am_q  <= '0;
      bm_q  <= '0;
      neg_q <= 1'b0;
      i_q   <= '0;
      j_q   <= '0;
      acc_q <= '0;
      p_q   <= '0;
      ov_q  <= 1'b0;
    end else if (enb) begin
      case (st_q)
        ST_IDLE: begin
          if (in_valid) begin
            am_q  <= AEXT'(a_abs);
            bm_q  <= BEXT'(b_abs);
            neg_q <= a_neg ^ b_neg;
            acc_q <= '0;
            i_q   <= '0;
            j_q   <= '0;
            st_q  <= ST_CALC;
          end
        end
        ST_CALC: begin
          acc_q <= acc_d;
          if (i_last && j_last) begin
            p_q  <= p_d;
            ov_q <= 1'b1;
            i_q  <= '0;
            j_q  <= '0;
            st_q <= ST_DONE;
          end else if (i_last) begin
            i_q <= '0;
            j_q <= j_q + IW_B'(1);
          end else begin
            i_q <= i_q + IW_A'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            ov_q <= 1'b0;
            st_q <= ST_IDLE;
          end
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  // Held low while reset is asserted so nothing is offered before release.
  assign in_ready  = (st_q == ST_IDLE) && !rst;
  assign out_valid = ov_q;
  assign p         = p_q;

endmodule

// File: tb/tb_math_mult_seq.sv
// Bench for math_mult_seq: default-size unsigned/signed instances plus
// 16x16 single-tile instances, checked against a queue-based scoreboard.
module tb_math_mult_seq;

  logic clk = 1'b0;
  logic rst, enb;
  always #5 clk = ~clk;

  logic        iv_b, or_b;
  logic [42:0] a_b;
  logic [34:0] b_b;
  logic        rdy_du, ov_du, rdy_ds, ov_ds;
  logic [77:0] p_du, p_ds;

  logic        iv_s, or_s;
  logic [15:0] a_s, b_s;
  logic        rdy_su, ov_su, rdy_ss, ov_ss;
  logic [31:0] p_su, p_ss;

  math_mult_seq #(.WIDTH_A(43), .WIDTH_B(35), .TILE(17), .SIGNED(0)) u_du (
    .clk(clk), .rst(rst), .enb(enb), .in_valid(iv_b), .in_ready(rdy_du),
    .a(a_b), .b(b_b), .out_valid(ov_du), .out_ready(or_b), .p(p_du));
  math_mult_seq #(.WIDTH_A(43), .WIDTH_B(35), .TILE(17), .SIGNED(1)) u_ds (
    .clk(clk), .rst(rst), .enb(enb), .in_valid(iv_b), .in_ready(rdy_ds),
    .a(a_b), .b(b_b), .out_valid(ov_ds), .out_ready(or_b), .p(p_ds));
  math_mult_seq #(.WIDTH_A(16), .WIDTH_B(16), .TILE(17), .SIGNED(0)) u_su (
    .clk(clk), .rst(rst), .enb(enb), .in_valid(iv_s), .in_ready(rdy_su),
    .a(a_s), .b(b_s), .out_valid(ov_su), .out_ready(or_s), .p(p_su));
  math_mult_seq #(.WIDTH_A(16), .WIDTH_B(16), .TILE(17), .SIGNED(1)) u_ss (
    .clk(clk), .rst(rst), .enb(enb), .in_valid(iv_s), .in_ready(rdy_ss),
    .a(a_s), .b(b_s), .out_valid(ov_ss), .out_ready(or_s), .p(p_ss));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int hs      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [77:0] q_du[$], q_ds[$];
  logic [31:0] q_su[$], q_ss[$];

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref32(input logic [15:0] x, input logic [15:0] y, input bit sgn);
    if (sgn) return {{16{x[15]}}, x} * {{16{y[15]}}, y};
    return {16'b0, x} * {16'b0, y};
  endfunction

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Scoreboard: pop and compare whenever a product is actually taken.
  always @(negedge clk) begin
    logic [77:0] e78;
    logic [31:0] e32;
    if (!rst && enb && or_b) begin
      if (ov_du) begin
        if (q_du.size() == 0) begin n_tests++; n_fail++; $display("FAIL du_extra p=%0h", p_du); end
        else begin e78 = q_du.pop_front(); chk("du_p", 128'(p_du), 128'(e78)); end
      end
      if (ov_ds) begin
        if (q_ds.size() == 0) begin n_tests++; n_fail++; $display("FAIL ds_extra p=%0h", p_ds); end
        else begin e78 = q_ds.pop_front(); chk("ds_p", 128'(p_ds), 128'(e78)); end
      end
    end
    if (!rst && enb && or_s) begin
      if (ov_su) begin
        if (q_su.size() == 0) begin n_tests++; n_fail++; $display("FAIL su_extra p=%0h", p_su); end
        else begin e32 = q_su.pop_front(); chk("su_p", 128'(p_su), 128'(e32)); end
      end
      if (ov_ss) begin
        if (q_ss.size() == 0) begin n_tests++; n_fail++; $display("FAIL ss_extra p=%0h", p_ss); end
        else begin e32 = q_ss.pop_front(); chk("ss_p", 128'(p_ss), 128'(e32)); end
      end
    end
  end

  task automatic send_big(input logic [42:0] av, input logic [34:0] bv,
                          input logic [77:0] eu, input logic [77:0] es);
    int t = 0;
    @(posedge clk); #1;
    while (!(rdy_du && rdy_ds) && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) begin n_tests++; n_fail++; $display("FAIL rdy_timeout got=0 exp=1"); end
    iv_b = 1'b1; a_b = av; b_b = bv;
    @(posedge clk);
    q_du.push_back(eu); q_ds.push_back(es);
    #1;
    hs = cyc;
    iv_b = 1'b0;
    a_b = {11'($urandom), $urandom};
    b_b = {3'($urandom), $urandom};
  endtask

  task automatic wait_big(output int lat);
    int t = 0;
    do begin @(negedge clk); t++; end while (!ov_du && t < 100);
    lat = ov_du ? (cyc - hs) : -1;
  endtask

  typedef struct {
    logic [42:0] a;
    logic [34:0] b;
    logic [77:0] eu;
    logic [77:0] es;
  } vec_t;
  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int lat, seen;
    logic [3:0] ovb;
    logic [15:0] xa, xb;

    tbl[0] = '{a: 43'h7FF_FFFF_FFFF, b: 35'h7_FFFF_FFFF,
               eu: ((78'd1 << 43) - 78'd1) * ((78'd1 << 35) - 78'd1), es: 78'd1};
    tbl[1] = '{a: 43'h7FF_FFFF_FFFF, b: 35'd1,
               eu: (78'd1 << 43) - 78'd1, es: {78{1'b1}}};
    tbl[2] = '{a: 43'h400_0000_0000, b: 35'h4_0000_0000,
               eu: 78'd1 << 76, es: 78'd1 << 76};
    tbl[3] = '{a: 43'd0, b: 35'h7_FFFF_FFFF, eu: 78'd0, es: 78'd0};
    tbl[4] = '{a: 43'h7FF_FFFF_FFFF, b: 35'd0, eu: 78'd0, es: 78'd0};
    tbl[5] = '{a: 43'h7FF_FFFF_FFF9, b: 35'd9,
               eu: ((78'd1 << 43) - 78'd7) * 78'd9, es: 78'd0 - 78'd63};
    tbl[6] = '{a: 43'd3, b: 35'd5, eu: 78'd15, es: 78'd15};
    tbl[7] = '{a: 43'h123_4567_89AB, b: 35'h1_DEAD_BEEF,
               eu: 78'h123_4567_89AB * 78'h1_DEAD_BEEF, es: 78'h123_4567_89AB * 78'h1_DEAD_BEEF};
    tbl[8] = '{a: 43'd5, b: 35'h7_FFFF_FFFF,
               eu: 78'd5 * ((78'd1 << 35) - 78'd1), es: 78'd0 - 78'd5};

    rst = 1'b1; enb = 1'b1;
    iv_b = 1'b0; or_b = 1'b1; a_b = '0; b_b = '0;
    iv_s = 1'b0; or_s = 1'b1; a_s = '0; b_s = '0;

    // Reset state, then a handshake on the very first edge after release.
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 128'(rdy_du), 128'(0));
    chk("rst_out_valid", 128'({ov_du, ov_ds, ov_su, ov_ss}), 128'(0));
    chk("rst_p", 128'(p_du | p_ds), 128'(0));
    rst = 1'b0;
    iv_b = 1'b1; a_b = 43'd11; b_b = 35'd13;
    #1 chk("rel_in_ready", 128'({rdy_du, rdy_ds, rdy_su, rdy_ss}), 128'(4'hF));
    @(posedge clk);
    q_du.push_back(78'd143); q_ds.push_back(78'd143);
    #1 hs = cyc; iv_b = 1'b0;
    wait_big(lat);
    chk("first_lat", 128'(lat), 128'(9));

    foreach (tbl[i]) begin
      send_big(tbl[i].a, tbl[i].b, tbl[i].eu, tbl[i].es);
      wait_big(lat);
      chk("tbl_lat", 128'(lat), 128'(9));
      chk("tbl_ds_valid", 128'(ov_ds), 128'(1));
    end

    // Backpressure in DONE for 5 cycles.
    @(posedge clk); #1 or_b = 1'b0;
    send_big(tbl[0].a, tbl[0].b, tbl[0].eu, tbl[0].es);
    wait_big(lat);
    chk("bp_lat", 128'(lat), 128'(9));
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_valid", 128'({ov_du, ov_ds}), 128'(2'b11));
      chk("bp_p", 128'(p_du), 128'(tbl[0].eu));
      chk("bp_in_ready", 128'(rdy_du), 128'(0));
    end
    @(posedge clk); #1 or_b = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle", 128'({rdy_du, ov_du}), 128'(2'b10));

    // Clock enable low for 3 cycles mid-CALC.
    send_big(tbl[7].a, tbl[7].b, tbl[7].eu, tbl[7].es);
    repeat (3) @(posedge clk);
    #1 enb = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("enb_frozen", 128'({ov_du, rdy_du}), 128'(0));
      @(posedge clk);
    end
    #1 enb = 1'b1;
    wait_big(lat);
    chk("enb_lat", 128'(lat), 128'(12));

    // Reset pulse at CALC step 4 discards the operation.
    send_big(tbl[0].a, tbl[0].b, tbl[0].eu, tbl[0].es);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    q_du.delete(); q_ds.delete();
    #2 chk("midrst_state", 128'({rdy_du, ov_du, p_du}), 128'(0));
    @(negedge clk) rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      seen += int'(ov_du | ov_ds);
    end
    chk("midrst_no_valid", 128'(seen), 128'(0));
    send_big(43'd3, 35'd5, 78'd15, 78'd15);
    wait_big(lat);
    chk("midrst_next_lat", 128'(lat), 128'(9));

    // Single-tile instances: random pairs with corner values, latency 1.
    for (int n = 0; n < 10000; n++) begin
      @(posedge clk); #1;
      xa = pick16(); xb = pick16();
      iv_s = 1'b1; a_s = xa; b_s = xb;
      @(posedge clk);
      q_su.push_back(ref32(xa, xb, 1'b0));
      q_ss.push_back(ref32(xa, xb, 1'b1));
      #1 iv_s = 1'b0; a_s = 16'($urandom); b_s = 16'($urandom);
      @(negedge clk) ovb[3:2] = {ov_su, ov_ss};
      @(negedge clk) ovb[1:0] = {ov_su, ov_ss};
      chk("small_lat", 128'(ovb), 128'(4'b0011));
    end

    repeat (5) @(negedge clk);
    chk("sb_empty", 128'(q_du.size() + q_ds.size() + q_su.size() + q_ss.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/math_mult_seq.md
MATH_MULT_SEQ -- requirements
Module: math_mult_seq

Interface
REQ-001 SHALL have parameter WIDTH_A, default 43: operand a width in bits, 2..128.
REQ-002 SHALL have parameter WIDTH_B, default 35: operand b width in bits, 2..128.
REQ-003 SHALL have parameter TILE, default 17: unsigned tile width per partial product, 8..25.
REQ-004 SHALL have parameter SIGNED, default 0: 0 = unsigned operands, 1 = two's-complement operands.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port enb  input  1  clock enable; low freezes all state and outputs.
REQ-008 SHALL have port in_valid  input  1  operand pair valid.
REQ-009 SHALL have port in_ready  output  1  block accepts an operand pair.
REQ-010 SHALL have port a  input  WIDTH_A  multiplicand.
REQ-011 SHALL have port b  input  WIDTH_B  multiplier.
REQ-012 SHALL have port out_valid  output  1  product valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the product.
REQ-014 SHALL have port p  output  WIDTH_A+WIDTH_B  full-precision product.

Function
REQ-015 SHALL compute p = a*b exactly; no truncation or rounding; signedness per SIGNED.
REQ-016 SHALL split operand magnitudes into NA = ceil(WIDTH_A/TILE) and NB = ceil(WIDTH_B/TILE) tiles, zero-extending the top tile.
REQ-017 SHALL use one TILE x TILE multiplier, time-shared; one tile pair per enabled cycle, partial product shifted by (i+j)*TILE and added to a WIDTH_A+WIDTH_B accumulator.
REQ-018 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE.
REQ-019 IDLE: in_ready=1; in_valid&in_ready&enb latches operands, clears the accumulator, and moves to CALC.
REQ-020 CALC: in_ready=0; step tile indices b-major (j outer, i inner); leave for DONE after NA*NB steps.
REQ-021 DONE: out_valid=1; p holds the final value; out_ready&enb returns to IDLE.
REQ-022 SHALL use a handshake with no overlap: in_ready=0 in CALC and DONE; no new operand is accepted in the cycle the product is taken.
REQ-023 Latency: if the input handshake completes at edge k with enb held high, out_valid SHALL rise after edge k+NA*NB (the defaults give 9 CALC cycles).
REQ-024 Each enb-low cycle SHALL extend latency by exactly one cycle; in_ready, out_valid and p SHALL remain stable.
REQ-025 SIGNED=1: SHALL multiply the magnitudes |a| and |b| (WIDTH bits, so -2^(W-1) is representable) and negate in the CALC->DONE transition if sign(a) XOR sign(b).
REQ-026 A zero operand SHALL still take the full NA*NB cycles and yield p=0.
REQ-027 p and out_valid SHALL stay stable while out_valid=1 and out_ready=0, for unbounded backpressure.
REQ-028 a and b are sampled only at the input handshake; later changes SHALL NOT affect p.

Reset
REQ-029 rst high SHALL asynchronously force IDLE with in_ready=0 during reset and 1 after release, out_valid=0, p=0, the accumulator and tile indices zeroed.
REQ-030 rst during CALC or DONE SHALL discard the operation; no out_valid pulse may follow.
REQ-031 The first handshake SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-032 Shared package math_pkg SHALL hold the ceil-div function, the FSM state encodings (IDLE=0, CALC=1, DONE=2), and the default TILE constant.
REQ-033 Sub-module math_mult_tile: combinational unsigned TILE x TILE multiply returning 2*TILE bits, mapping onto one DSP slice; instantiated once.
REQ-034 Operand/tile select muxes and the accumulator SHALL reside in math_mult_seq; the body SHALL be 120-400 lines.

Verification
REQ-035 Defaults, SIGNED=0, a=2^43-1, b=2^35-1 -> p=(2^43-1)(2^35-1), out_valid 9 cycles after the handshake edge.
REQ-036 SIGNED=1, a=-1, b=1 -> p = all ones (78 bits); a=-2^42, b=-2^34 -> p=2^76.
REQ-037 out_ready held low for 5 cycles in DONE -> p and out_valid unchanged, in_ready=0 throughout, IDLE on the 6th cycle with out_ready=1.
REQ-038 enb low for 3 cycles mid-CALC -> out_valid at 12 cycles; product correct.
REQ-039 rst pulsed at CALC step 4 -> out_valid never asserts; the next operand pair a=3, b=5 -> p=15.
REQ-040 WIDTH_A=16, WIDTH_B=16, TILE=17 (NA=NB=1), 10,000 random pairs each mode -> all match the reference model, latency 1.
